// File: rtl/instr_fetch_seq_pkg.sv
// Shared definitions for the fetch sequencer: FSM states, IR field layout, icodes.
package instr_fetch_seq_pkg;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_FETCH_I = 3'd1,
      S_DECODE  = 3'd2,
      S_FETCH_D = 3'd3,
      S_ISSUE   = 3'd4,
      S_EXEC    = 3'd5,
      S_HALT    = 3'd6
   } state_t;

   // IR[15:0] layout, fixed regardless of DATA_W
   localparam int HALT_BIT  = 15;
   localparam int ICODE_MSB = 14;
   localparam int ICODE_LSB = 13;
   localparam int IMM_BIT   = 12;

   // Instruction codes in IR[14:13], shared with the processor's control FSM
   typedef enum logic [1:0] {
      IC_MV  = 2'd0,
      IC_MVT = 2'd1,
      IC_ADD = 2'd2,
      IC_SUB = 2'd3
   } icode_t;

endpackage

// File: rtl/instr_fetch_seq_if.sv
// Program memory read port: request held until a one-cycle ack with data.
interface instr_fetch_seq_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 16
);
   logic              req;
   logic [ADDR_W-1:0] addr;
   logic              ack;
   logic [DATA_W-1:0] rdata;

   modport master (output req, addr, input ack, rdata);
   modport slave  (input req, addr, output ack, rdata);
endinterface

// File: rtl/instr_fetch_seq_wdog.sv
// Execution watchdog: counts EXEC cycles and flags the cycle whose increment
// reaches all-ones, so the timeout lands after 2**WDOG_W-1 EXEC cycles.
module fetch_wdog #(
   parameter int WDOG_W = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic sat
);
   localparam logic [WDOG_W-1:0] MAX = '1;

   logic [WDOG_W-1:0] cnt;

   assign sat = en && (cnt == MAX - WDOG_W'(1));

   // Clear wins over enable; the count parks at all-ones
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                  cnt <= '0;
      else if (clr)              cnt <= '0;
      else if (en && cnt != MAX) cnt <= cnt + WDOG_W'(1);
   end
endmodule

// File: rtl/instr_fetch_seq.sv
// Instruction fetch sequencer: loads IR (and DIN for immediates) from program
// memory, pulses run, waits for Done, and stops on halt or watchdog timeout.
module instr_fetch_seq
   import instr_fetch_seq_pkg::*;
#(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 16,
   parameter int WDOG_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] start_addr,
   instr_fetch_seq_if.master mem,
   output logic [DATA_W-1:0] ir,
   output logic [DATA_W-1:0] din,
   output logic              run,
   input  logic              proc_done,
   output logic [ADDR_W-1:0] pc,
   output logic              busy,
   output logic              halted,
   output logic              wdog_err
);
   state_t            state;
   logic              req_q;
   logic [ADDR_W-1:0] addr_q;
   logic              wdog_sat;

   assign mem.req  = req_q;
   assign mem.addr = addr_q;

   fetch_wdog #(.WDOG_W(WDOG_W)) u_wdog (
      .clk (clk),
      .rst (rst),
      .clr (state == S_ISSUE),
      .en  (state == S_EXEC),
      .sat (wdog_sat)
   );

   // Sequencer FSM; every output is registered and set on entry to its state
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= S_IDLE;
         pc       <= '0;
         ir       <= '0;
         din      <= '0;
         req_q    <= 1'b0;
         addr_q   <= '0;
         run      <= 1'b0;
         busy     <= 1'b0;
         halted   <= 1'b0;
         wdog_err <= 1'b0;
      end else begin
         run <= 1'b0;
         case (state)
            // HALT is left the same way as IDLE: a new start
            S_IDLE, S_HALT: begin
               if (start) begin
                  pc       <= start_addr;
                  addr_q   <= start_addr;
                  req_q    <= 1'b1;
                  wdog_err <= 1'b0;
                  busy     <= 1'b1;
                  halted   <= 1'b0;
                  state    <= S_FETCH_I;
               end
            end
            S_FETCH_I: begin
               if (mem.ack) begin
                  ir    <= mem.rdata;
                  pc    <= pc + ADDR_W'(1);
                  req_q <= 1'b0;
                  state <= S_DECODE;
               end
            end
            S_DECODE: begin
               if (ir[HALT_BIT]) begin
                  busy   <= 1'b0;
                  halted <= 1'b1;
                  state  <= S_HALT;
               end else if (ir[IMM_BIT]) begin
                  addr_q <= pc;
                  req_q  <= 1'b1;
                  state  <= S_FETCH_D;
               end else begin
                  run   <= 1'b1;
                  state <= S_ISSUE;
               end
            end
            S_FETCH_D: begin
               if (mem.ack) begin
                  din   <= mem.rdata;
                  pc    <= pc + ADDR_W'(1);
                  req_q <= 1'b0;
                  run   <= 1'b1;
                  state <= S_ISSUE;
               end
            end
            // Done is stale here (reported while the processor was idle)
            S_ISSUE: state <= S_EXEC;
            // A Done in the same cycle as the timeout still counts as completion
            S_EXEC: begin
               if (proc_done) begin
                  addr_q <= pc;
                  req_q  <= 1'b1;
                  state  <= S_FETCH_I;
               end else if (wdog_sat) begin
                  wdog_err <= 1'b1;
                  busy     <= 1'b0;
                  halted   <= 1'b1;
                  state    <= S_HALT;
               end
            end
            default: begin
               req_q  <= 1'b0;
               busy   <= 1'b0;
               halted <= 1'b0;
               state  <= S_IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_instr_fetch_seq.sv
// Bench for instr_fetch_seq: directed scenarios plus randomized programs
// checked against a program-walk reference model.
module tb_instr_fetch_seq;
   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [7:0]  start_addr;
   logic [15:0] ir, din;
   logic        run, proc_done;
   logic [7:0]  pc;
   logic        busy, halted, wdog_err;

   instr_fetch_seq_if #(.ADDR_W(8), .DATA_W(16)) mif ();

   instr_fetch_seq #(.ADDR_W(8), .DATA_W(16), .WDOG_W(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .start_addr (start_addr),
      .mem        (mif),
      .ir         (ir),
      .din        (din),
      .run        (run),
      .proc_done  (proc_done),
      .pc         (pc),
      .busy       (busy),
      .halted     (halted),
      .wdog_err   (wdog_err)
   );

   always #5 clk = ~clk;

   // memory and processor models
   logic [15:0] mem_arr [256];
   int  ack_wait  = 0;
   bit  stray     = 0;
   int  done_dly  = 1;
   bit  done_en   = 1;
   bit  idle_done = 0;
   int  wcnt      = 0;
   int  dcnt      = 0;

   // memory: ack after ack_wait wait cycles of held request
   always @(negedge clk) begin
      if (mif.req === 1'b1) begin
         wcnt    = wcnt + 1;
         mif.ack = (wcnt > ack_wait);
      end else begin
         wcnt    = 0;
         mif.ack = stray;
      end
      mif.rdata = mem_arr[mif.addr];
   end

   // processor: Done done_dly cycles after run
   always @(negedge clk) begin
      if (run === 1'b1) begin
         dcnt      = done_dly;
         proc_done = idle_done;
      end else if (dcnt > 0) begin
         dcnt      = dcnt - 1;
         proc_done = (dcnt == 0) && done_en;
      end else begin
         proc_done = idle_done;
      end
   end

   int ntests = 0;
   int nfail  = 0;

   logic [15:0] q_ir  [$];
   logic [15:0] q_din [$];
   logic [7:0]  q_pc  [$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ntests++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic go(input logic [7:0] a);
      start_addr = a;
      start      = 1'b1;
      step();
      start      = 1'b0;
   endtask

   task automatic run_to_issue(input int maxc, output int cyc, output int rises);
      logic prev;
      cyc   = 0;
      rises = mif.req ? 1 : 0;
      prev  = mif.req;
      while (run !== 1'b1 && cyc < maxc) begin
         step();
         cyc++;
         if (mif.req && !prev) rises++;
         prev = mif.req;
      end
   endtask

   task automatic run_to_halt(input int maxc, output int cyc, output int runs);
      cyc  = 0;
      runs = 0;
      while (halted !== 1'b1 && cyc < maxc) begin
         step();
         cyc++;
         if (run) runs++;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: observed no finish expected finish");
      $fatal(1);
   end

   initial begin
      int cyc, n, reqs;
      rst = 1'b0; start = 1'b0; start_addr = 8'h00;
      foreach (mem_arr[i]) mem_arr[i] = 16'h8000;

      // 1: reset state, 1-word instruction
      step(); step();
      chk("rst_ir", ir, 0);       chk("rst_din", din, 0);
      chk("rst_pc", pc, 0);       chk("rst_req", mif.req, 0);
      chk("rst_addr", mif.addr, 0); chk("rst_run", run, 0);
      chk("rst_busy", busy, 0);   chk("rst_halted", halted, 0);
      chk("rst_wdog", wdog_err, 0);
      rst = 1'b1;
      mem_arr[8'h10] = 16'h0003; mem_arr[8'h11] = 16'h8000;
      go(8'h10);
      chk("t1_req", mif.req, 1); chk("t1_addr", mif.addr, 8'h10); chk("t1_busy", busy, 1);
      run_to_issue(20, cyc, n);
      chk("t1_lat", cyc, 2); chk("t1_ir", ir, 16'h0003); chk("t1_pc", pc, 8'h11); chk("t1_din", din, 0);
      cyc = 0;
      while (!mif.req && cyc < 10) begin step(); cyc++; end
      chk("t1_next_req", mif.req, 1); chk("t1_next_addr", mif.addr, 8'h11);
      run_to_halt(20, cyc, n);
      chk("t1_halted", halted, 1); chk("t1_busy_h", busy, 0); chk("t1_pc_h", pc, 8'h12);

      // 2: instruction with immediate operand
      mem_arr[8'h10] = 16'h1000; mem_arr[8'h11] = 16'h00A5; mem_arr[8'h12] = 16'h8000;
      go(8'h10);
      run_to_issue(20, cyc, n);
      chk("t2_lat", cyc, 3); chk("t2_fetches", n, 2); chk("t2_din", din, 16'h00A5);
      chk("t2_ir", ir, 16'h1000); chk("t2_pc", pc, 8'h12);
      run_to_halt(20, cyc, n);
      chk("t2_pc_h", pc, 8'h13);

      // 3: halt instruction
      mem_arr[8'h10] = 16'h8000;
      go(8'h10);
      run_to_halt(20, cyc, n);
      chk("t3_cyc", cyc, 2); chk("t3_runs", n, 0); chk("t3_halted", halted, 1); chk("t3_busy", busy, 0);
      reqs = 0;
      for (int i = 0; i < 5; i++) begin step(); if (mif.req) reqs++; end
      chk("t3_no_req", reqs, 0);

      // 4: watchdog timeout on add with Done held low
      done_en = 1'b0;
      mem_arr[8'h10] = 16'h4001; mem_arr[8'h11] = 16'h8000;
      go(8'h10);
      run_to_issue(20, cyc, n);
      run_to_halt(40, cyc, n);
      chk("t4_exec_cycles", cyc, 16); chk("t4_runs", n, 0);
      chk("t4_wdog", wdog_err, 1); chk("t4_halted", halted, 1); chk("t4_pc", pc, 8'h11);
      done_en = 1'b1;

      // 5: operand wraps to address 0
      mem_arr[8'hFF] = 16'h1000; mem_arr[8'h00] = 16'h1234; mem_arr[8'h01] = 16'h8000;
      go(8'hFF);
      chk("t5_wdog_clr", wdog_err, 0);
      step(); step();
      chk("t5_op_req", mif.req, 1); chk("t5_op_addr", mif.addr, 8'h00);
      run_to_issue(20, cyc, n);
      chk("t5_din", din, 16'h1234); chk("t5_pc", pc, 8'h01);
      run_to_halt(20, cyc, n);
      chk("t5_pc_h", pc, 8'h02);

      // 6: reset during a delayed fetch
      ack_wait = 3;
      mem_arr[8'h20] = 16'h0003;
      go(8'h20);
      step();
      chk("t6_waiting", mif.req, 1);
      #2 rst = 1'b0;
      #1;
      chk("t6_req", mif.req, 0); chk("t6_ir", ir, 0); chk("t6_din", din, 0);
      chk("t6_pc", pc, 0); chk("t6_addr", mif.addr, 0); chk("t6_run", run, 0);
      chk("t6_busy", busy, 0); chk("t6_halted", halted, 0); chk("t6_wdog", wdog_err, 0);
      @(posedge clk); #1 rst = 1'b1;
      reqs = 0;
      for (int i = 0; i < 4; i++) begin step(); if (mif.req || busy) reqs++; end
      chk("t6_idle", reqs, 0);
      ack_wait = 0;

      // randomized programs against the program-walk model
      for (int it = 0; it < 20; it++) begin
         logic [7:0]  a, sa;
         logic [15:0] w, d, mdin;
         int          k;
         mdin      = din_model_seed(it);
         sa        = 8'($urandom);
         a         = sa;
         k         = $urandom_range(1, 5);
         ack_wait  = $urandom_range(0, 2);
         done_dly  = $urandom_range(1, 5);
         idle_done = 1'($urandom_range(0, 1));
         stray     = (ack_wait == 0) && ($urandom_range(0, 1) == 1);
         q_ir.delete(); q_din.delete(); q_pc.delete();
         for (int j = 0; j < k; j++) begin
            w = 16'($urandom) & 16'h7FFF;
            mem_arr[a] = w; a = a + 8'd1;
            if (w[12]) begin
               d = 16'($urandom);
               mem_arr[a] = d; a = a + 8'd1;
               mdin = d;
            end
            q_ir.push_back(w); q_din.push_back(mdin); q_pc.push_back(a);
         end
         w = 16'($urandom) | 16'h8000;
         mem_arr[a] = w; a = a + 8'd1;
         go(sa);
         for (int c = 0; c < 400 && halted !== 1'b1; c++) begin
            step();
            if (run) begin
               if (q_ir.size() == 0) chk("rnd_extra_run", 1, 0);
               else begin
                  chk("rnd_ir", ir, q_ir.pop_front());
                  chk("rnd_din", din, q_din.pop_front());
                  chk("rnd_pc", pc, q_pc.pop_front());
               end
            end
         end
         chk("rnd_halted", halted, 1);
         chk("rnd_missing_runs", q_ir.size(), 0);
         chk("rnd_pc_h", pc, a);
         chk("rnd_ir_h", ir, w);
         chk("rnd_wdog", wdog_err, 0);
         last_din = din;
      end
      stray = 1'b0;

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

   // din persists across programs; model carries the last loaded operand forward
   logic [15:0] last_din = 16'h0000;
   function automatic logic [15:0] din_model_seed(input int it);
      return (it == 0) ? 16'h0000 : last_din;
   endfunction
endmodule
